aibio_bias_trim_cal_ctrl: RTL and testbench

AIBIO_BIAS_TRIM_CAL_CTRL -- requirements
Module: aibio_bias_trim_cal_ctrl

---
 rtl/aibio_bias_cal_pkg.sv | 6 +
 rtl/aibio_cal_sync2.sv | 13 +
 rtl/aibio_bias_trim_cal_ctrl.sv | 98 +++++++++
 tb/tb_aibio_bias_trim_cal_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/aibio_bias_cal_pkg.sv
// aibio_bias_cal_pkg: shared state encoding and trim constants for the bias calibration controller
package aibio_bias_cal_pkg;
  localparam int TRIM_W_DEF = 3;
  localparam logic [TRIM_W_DEF-1:0] TRIM_MID = 3'b100;
  typedef enum logic [2:0] {IDLE, SETUP, SETTLE, SAMPLE, DONE} cal_state_e;
endpackage

// File: rtl/aibio_cal_sync2.sv
// aibio_cal_sync2: two-flop synchronizer for the asynchronous bias comparator
module aibio_cal_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic meta;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) {o_q, meta} <= 2'b00;
    else {o_q, meta} <= {meta, i_d};
  end
endmodule

// File: rtl/aibio_bias_trim_cal_ctrl.sv
// aibio_bias_trim_cal_ctrl: SAR search of the bias trim code against a comparator, with override and abort
module aibio_bias_trim_cal_ctrl
  import aibio_bias_cal_pkg::*;
#(
  parameter int TRIM_W   = TRIM_W_DEF,
  parameter int SETTLE_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_cal_en,
  input  logic                i_bypass,
  input  logic [TRIM_W-1:0]   i_trim_ovrd,
  input  logic [SETTLE_W-1:0] i_settle_cyc,
  input  logic                i_cmp,
  output logic [TRIM_W-1:0]   o_bias_trim,
  output logic                o_cal_busy,
  output logic                o_cal_done,
  output logic                o_cal_err
);
  localparam int PTR_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  // Midscale rescaled from the package constant to the configured width
  localparam logic [TRIM_W-1:0] MID = TRIM_W'({TRIM_MID, {TRIM_W{1'b0}}} >> TRIM_W_DEF);
  cal_state_e state;
  logic [TRIM_W-1:0] trial, result, pick, trial_s;
  logic [PTR_W-1:0] ptr;
  logic [SETTLE_W-1:0] cnt;
  logic cmp_s;
  aibio_cal_sync2 u_sync (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_cmp), .o_q(cmp_s));
  assign pick = TRIM_W'(1) << ptr;
  assign trial_s = cmp_s ? trial : trial & ~pick;
  // o_cal_busy mirrors the search states, so it doubles as the abort qualifier
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      trial <= '0;
      ptr <= '0;
      cnt <= '0;
      result <= MID;
      o_bias_trim <= MID;
      o_cal_busy <= 1'b0;
      o_cal_done <= 1'b0;
      o_cal_err <= 1'b0;
    end else if (i_bypass) begin
      state <= IDLE;
      o_bias_trim <= i_trim_ovrd;
      o_cal_busy <= 1'b0;
      o_cal_done <= 1'b0;
      o_cal_err <= 1'b0;
    end else if (o_cal_busy && !i_cal_en) begin
      state <= IDLE;
      o_bias_trim <= result;
      o_cal_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_bias_trim <= result;
          o_cal_done <= 1'b0;
          o_cal_err <= 1'b0;
          if (i_cal_en) begin
            state <= SETUP;
            trial <= '0;
            ptr <= PTR_W'(TRIM_W - 1);
            o_cal_busy <= 1'b1;
          end
        end
        SETUP: begin
          trial <= trial | pick;
          o_bias_trim <= trial | pick;
          cnt <= (i_settle_cyc == '0) ? SETTLE_W'(1) : i_settle_cyc;
          state <= SETTLE;
        end
        SETTLE: begin
          cnt <= cnt - SETTLE_W'(1);
          state <= (cnt == SETTLE_W'(1)) ? SAMPLE : SETTLE;
        end
        SAMPLE: begin
          trial <= trial_s;
          if (ptr != '0) begin
            ptr <= ptr - PTR_W'(1);
            state <= SETUP;
          end else begin
            result <= trial_s;
            o_bias_trim <= trial_s;
            o_cal_busy <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          o_bias_trim <= result;
          o_cal_done <= 1'b1;
          o_cal_err <= (&result) | ~(|result);
          state <= i_cal_en ? DONE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aibio_bias_trim_cal_ctrl.sv
// tb_aibio_bias_trim_cal_ctrl: directed scoreboard bench for the bias trim calibration controller
module tb_aibio_bias_trim_cal_ctrl;
  import aibio_bias_cal_pkg::*;
  typedef struct {logic [2:0] trim; logic err; int lat;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, cal_en = 1'b0, bypass = 1'b0, cmp;
  logic [2:0] trim_ovrd = '0, bias_trim;
  logic [7:0] settle_cyc = 8'd4;
  logic busy, done, err;
  int thr = 7, cyc = 0, checks = 0, errors = 0;
  exp_t q[$];
  aibio_bias_trim_cal_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cal_en(cal_en), .i_bypass(bypass),
    .i_trim_ovrd(trim_ovrd), .i_settle_cyc(settle_cyc), .i_cmp(cmp),
    .o_bias_trim(bias_trim), .o_cal_busy(busy), .o_cal_done(done), .o_cal_err(err)
  );
  always #5 clk = ~clk;
  // Comparator model: bias is low (more trim needed) while the ladder code is at or below thr
  assign cmp = (int'(bias_trim) <= thr);
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start(input int t, input logic [7:0] s);
    thr = t;
    settle_cyc = s;
    cal_en = 1'b1;
    tick();
    cyc = 0;
    check("busy_after_start", busy, 1);
  endtask
  task automatic push_exp(input logic [2:0] trim, input logic e, input logic [7:0] s);
    int n;
    n = (s == 0) ? 1 : int'(s);
    q.push_back('{trim: trim, err: e, lat: 3 * (n + 2) + 1});
  endtask
  task automatic wait_done();
    exp_t e;
    e = q.pop_front();
    while (done !== 1'b1 && cyc < 200) tick();
    check("done_latency", cyc, e.lat);
    check("result_trim", bias_trim, e.trim);
    check("result_err", err, e.err);
    check("busy_in_done", busy, 0);
  endtask
  task automatic run(input int t, input logic [7:0] s, input logic [2:0] trim, input logic e);
    push_exp(trim, e, s);
    start(t, s);
    wait_done();
  endtask
  task automatic release_done(input logic [2:0] trim);
    cal_en = 1'b0;
    tick();
    tick();
    check("done_cleared", done, 0);
    check("err_cleared", err, 0);
    check("trim_retained", bias_trim, trim);
  endtask
  initial begin
    tick();
    tick();
    check("rst_trim", bias_trim, 32'(TRIM_MID));
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    tick();
    // Nominal, with a settle change confined to the first SETTLE window
    push_exp(3'd5, 1'b0, 8'd4);
    start(5, 8'd4);
    tick();
    tick();
    settle_cyc = 8'd0;
    tick();
    tick();
    settle_cyc = 8'd4;
    wait_done();
    release_done(3'd5);
    run(7, 8'd0, 3'd7, 1'b1);
    release_done(3'd7);
    // Abort in the second SETTLE after a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    start(5, 8'd4);
    repeat (8) tick();
    check("busy_second_settle", busy, 1);
    cal_en = 1'b0;
    tick();
    check("abort_trim", bias_trim, 4);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (3) tick();
    check("abort_done_later", done, 0);
    // Bypass mid-search
    start(3, 8'd4);
    repeat (3) tick();
    trim_ovrd = 3'd2;
    bypass = 1'b1;
    tick();
    check("bypass_trim", bias_trim, 2);
    check("bypass_busy", busy, 0);
    check("bypass_done", done, 0);
    check("bypass_err", err, 0);
    repeat (4) tick();
    check("bypass_hold_busy", busy, 0);
    cal_en = 1'b0;
    bypass = 1'b0;
    tick();
    check("unbypass_trim", bias_trim, 4);
    // Rerun: an aborted second search must not disturb the stored result
    run(6, 8'd4, 3'd6, 1'b0);
    release_done(3'd6);
    start(1, 8'd3);
    repeat (4) tick();
    cal_en = 1'b0;
    tick();
    check("rerun_abort_trim", bias_trim, 6);
    tick();
    run(1, 8'd3, 3'd1, 1'b0);
    release_done(3'd1);
    run(-1, 8'd2, 3'd0, 1'b1);
    release_done(3'd0);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
